init_write_sequencer: RTL and testbench

- Consumes the address/data init streams from the power-on init generator for the BTB, the BHT and the register file.
- Turns each stream into exactly one clean, ordered write sweep per table, then hands the table write ports over to the pipeline.
- Holds the CPU stalled until all three tables are initialised.
- Sits between the init generator and the BTB, BHT and register-file write ports.

---
 rtl/init_write_sequencer.sv | 248 ++++++++++++++++++++++++
 tb/tb_init_write_sequencer.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/init_write_sequencer.sv
// ---------------------------------------------------------------------------
// init_write_sequencer
//
// Purpose:
//   Sits between the power-on init generator and the BTB, BHT and register
//   file write ports. The generator streams (addr, data) pairs per table, but
//   not necessarily starting at address 0. This block takes one clean,
//   in-order sweep (0 .. DEPTH-1) from each stream and writes it. It keeps the
//   pipeline stalled until all three tables are initialised, and then hands
//   the write ports over to the pipeline.
//
// Ports:
//   clk, rst_ni              clock, synchronous active-low reset
//   init_req_i               one-cycle pulse: redo the whole initialisation
//   gen_{btb,bht,reg}_*_i    generator init streams (addr + data per table)
//   cpu_{btb,bht,reg}_*_i    pipeline write ports (used only once DONE)
//   {btb,bht,reg}_*_o        registered table write ports
//   cpu_stall_o              high while any table is still uninitialised
//   init_done_o              high once all tables are initialised
//   seq_err_o                one-cycle pulse on an out-of-order generator addr
//
// Contents:
//   init_write_tracker       sweep tracker for one table
//   init_write_sequencer     top: three trackers plus the SWEEP/DONE FSM
// ---------------------------------------------------------------------------

// Tracks one table's sweep. It accepts generator addresses 0, 1, 2, ... in
// order. Any break in that order drops the partial sweep, and tracking resumes
// at the next address 0. Once DEPTH writes have been accepted the tracker goes
// quiet until it is cleared.
module init_write_tracker #(
    parameter  int DEPTH = 256,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_ni,
    input  logic          i_clear,   // restart the sweep from scratch
    input  logic [AW-1:0] i_addr,    // generator address this cycle
    output logic          o_we,      // accept this cycle's generator write
    output logic          o_err,     // out-of-order address seen mid-sweep
    output logic          o_done     // full sweep completed (sticky)
);

    logic          r_started;
    logic [CW-1:0] r_cnt;            // next expected address == writes so far
    logic          r_done;

    logic          w_started_nx;
    logic [CW-1:0] w_cnt_nx;
    logic          w_done_nx;
    logic          w_in_order;

    assign w_in_order = r_started && (CW'(i_addr) == r_cnt);
    assign o_done     = r_done;

    // NOTE: every signal driven here gets a default first, so no path through
    // the block leaves a value unassigned (which would infer a latch).
    always_comb begin
        w_started_nx = r_started;
        w_cnt_nx     = r_cnt;
        w_done_nx    = r_done;
        o_we         = 1'b0;
        o_err        = 1'b0;
        if (!r_done) begin
            if (w_in_order) begin
                o_we     = 1'b1;
                w_cnt_nx = r_cnt + CW'(1);
                if (w_cnt_nx == CW'(DEPTH)) begin
                    w_done_nx = 1'b1;
                end
            end else begin
                // Not started, or a break in the sequence. A break reports an
                // error. Either way an address 0 begins a fresh sweep at once.
                o_err = r_started;
                if (i_addr == '0) begin
                    o_we         = 1'b1;
                    w_started_nx = 1'b1;
                    w_cnt_nx     = CW'(1);
                    w_done_nx    = (DEPTH == 1);
                end else begin
                    w_started_nx = 1'b0;
                    w_cnt_nx     = '0;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_ni || i_clear) begin
            r_started <= 1'b0;
            r_cnt     <= '0;
            r_done    <= 1'b0;
        end else begin
            r_started <= w_started_nx;
            r_cnt     <= w_cnt_nx;
            r_done    <= w_done_nx;
        end
    end

endmodule

module init_write_sequencer #(
    parameter  int BTB_DEPTH = 256,
    parameter  int BHT_DEPTH = 256,
    parameter  int REG_DEPTH = 32,
    parameter  int BTB_W     = 40,
    parameter  int BHT_W     = 2,
    parameter  int REG_W     = 32,
    localparam int BTB_AW    = $clog2(BTB_DEPTH),
    localparam int BHT_AW    = $clog2(BHT_DEPTH),
    localparam int REG_AW    = $clog2(REG_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_ni,
    input  logic              init_req_i,
    input  logic [BTB_W-1:0]  gen_btb_data_i,
    input  logic [BTB_AW-1:0] gen_btb_addr_i,
    input  logic [BHT_W-1:0]  gen_bht_data_i,
    input  logic [BHT_AW-1:0] gen_bht_addr_i,
    input  logic [REG_W-1:0]  gen_reg_data_i,
    input  logic [REG_AW-1:0] gen_reg_addr_i,
    input  logic              cpu_btb_we_i,
    input  logic [BTB_AW-1:0] cpu_btb_addr_i,
    input  logic [BTB_W-1:0]  cpu_btb_data_i,
    input  logic              cpu_bht_we_i,
    input  logic [BHT_AW-1:0] cpu_bht_addr_i,
    input  logic [BHT_W-1:0]  cpu_bht_data_i,
    input  logic              cpu_reg_we_i,
    input  logic [REG_AW-1:0] cpu_reg_addr_i,
    input  logic [REG_W-1:0]  cpu_reg_data_i,
    output logic              btb_we_o,
    output logic [BTB_AW-1:0] btb_addr_o,
    output logic [BTB_W-1:0]  btb_data_o,
    output logic              bht_we_o,
    output logic [BHT_AW-1:0] bht_addr_o,
    output logic [BHT_W-1:0]  bht_data_o,
    output logic              reg_we_o,
    output logic [REG_AW-1:0] reg_addr_o,
    output logic [REG_W-1:0]  reg_data_o,
    output logic              cpu_stall_o,
    output logic              init_done_o,
    output logic              seq_err_o
);

    typedef enum logic {
        ST_SWEEP = 1'b0,
        ST_DONE  = 1'b1
    } state_t;

    state_t r_state;

    logic w_btb_we, w_btb_err, w_btb_done;
    logic w_bht_we, w_bht_err, w_bht_done;
    logic w_reg_we, w_reg_err, w_reg_done;
    logic w_all_done;
    logic w_btb_take, w_bht_take, w_reg_take;

    init_write_tracker #(.DEPTH(BTB_DEPTH)) u_btb_trk (
        .clk(clk), .rst_ni(rst_ni), .i_clear(init_req_i), .i_addr(gen_btb_addr_i),
        .o_we(w_btb_we), .o_err(w_btb_err), .o_done(w_btb_done)
    );
    init_write_tracker #(.DEPTH(BHT_DEPTH)) u_bht_trk (
        .clk(clk), .rst_ni(rst_ni), .i_clear(init_req_i), .i_addr(gen_bht_addr_i),
        .o_we(w_bht_we), .o_err(w_bht_err), .o_done(w_bht_done)
    );
    init_write_tracker #(.DEPTH(REG_DEPTH)) u_reg_trk (
        .clk(clk), .rst_ni(rst_ni), .i_clear(init_req_i), .i_addr(gen_reg_addr_i),
        .o_we(w_reg_we), .o_err(w_reg_err), .o_done(w_reg_done)
    );

    assign w_all_done = w_btb_done && w_bht_done && w_reg_done;

    // A re-init request during a sweep discards this cycle's generator beat:
    // the trackers are being cleared on the same edge.
    assign w_btb_take = w_btb_we && !init_req_i;
    assign w_bht_take = w_bht_we && !init_req_i;
    assign w_reg_take = w_reg_we && !init_req_i;

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            r_state     <= ST_SWEEP;
            btb_we_o    <= 1'b0;
            btb_addr_o  <= '0;
            btb_data_o  <= '0;
            bht_we_o    <= 1'b0;
            bht_addr_o  <= '0;
            bht_data_o  <= '0;
            reg_we_o    <= 1'b0;
            reg_addr_o  <= '0;
            reg_data_o  <= '0;
            cpu_stall_o <= 1'b1;
            init_done_o <= 1'b0;
            seq_err_o   <= 1'b0;
        end else begin
            case (r_state)
                ST_SWEEP: begin
                    // Only tracker writes reach the tables. Pipeline writes are
                    // dropped. Idle cycles drive zero address and data.
                    btb_we_o    <= w_btb_take;
                    btb_addr_o  <= w_btb_take ? gen_btb_addr_i : '0;
                    btb_data_o  <= w_btb_take ? gen_btb_data_i : '0;
                    bht_we_o    <= w_bht_take;
                    bht_addr_o  <= w_bht_take ? gen_bht_addr_i : '0;
                    bht_data_o  <= w_bht_take ? gen_bht_data_i : '0;
                    reg_we_o    <= w_reg_take;
                    reg_addr_o  <= w_reg_take ? gen_reg_addr_i : '0;
                    reg_data_o  <= w_reg_take ? gen_reg_data_i : '0;
                    seq_err_o   <= !init_req_i && (w_btb_err || w_bht_err || w_reg_err);
                    cpu_stall_o <= 1'b1;
                    init_done_o <= 1'b0;
                    if (!init_req_i && w_all_done) begin
                        r_state     <= ST_DONE;
                        cpu_stall_o <= 1'b0;
                        init_done_o <= 1'b1;
                    end
                end
                ST_DONE: begin
                    // Pipeline owns the ports. x0 is never rewritten, so it
                    // keeps its init value.
                    btb_we_o    <= cpu_btb_we_i;
                    btb_addr_o  <= cpu_btb_addr_i;
                    btb_data_o  <= cpu_btb_data_i;
                    bht_we_o    <= cpu_bht_we_i;
                    bht_addr_o  <= cpu_bht_addr_i;
                    bht_data_o  <= cpu_bht_data_i;
                    reg_we_o    <= cpu_reg_we_i && (cpu_reg_addr_i != '0);
                    reg_addr_o  <= cpu_reg_addr_i;
                    reg_data_o  <= cpu_reg_data_i;
                    seq_err_o   <= 1'b0;
                    cpu_stall_o <= 1'b0;
                    init_done_o <= 1'b1;
                    if (init_req_i) begin
                        r_state     <= ST_SWEEP;
                        cpu_stall_o <= 1'b1;
                        init_done_o <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_SWEEP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_init_write_sequencer.sv
// ---------------------------------------------------------------------------
// tb_init_write_sequencer
//
// Directed bench for init_write_sequencer. A per-table behavioural model
// (next expected index, or -1 while waiting for a 0) predicts every output
// cycle by cycle. A monitor gathers per-scenario statistics: write counts,
// first and last write edges, error pulses and the edge where init_done_o
// rises. These are checked against hand-computed literals.
// Edge numbering: edge 0 is the first rising edge sampled with rst_ni high.
// ---------------------------------------------------------------------------
module tb_init_write_sequencer;

    localparam int BTB_W = 40;
    localparam int BHT_W = 2;
    localparam int REG_W = 32;

    logic             clk = 1'b0;
    logic             rst_ni;
    logic             init_req_i;
    logic [BTB_W-1:0] gen_btb_data_i;
    logic [7:0]       gen_btb_addr_i;
    logic [BHT_W-1:0] gen_bht_data_i;
    logic [7:0]       gen_bht_addr_i;
    logic [REG_W-1:0] gen_reg_data_i;
    logic [4:0]       gen_reg_addr_i;
    logic             cpu_btb_we_i, cpu_bht_we_i, cpu_reg_we_i;
    logic [7:0]       cpu_btb_addr_i, cpu_bht_addr_i;
    logic [4:0]       cpu_reg_addr_i;
    logic [BTB_W-1:0] cpu_btb_data_i;
    logic [BHT_W-1:0] cpu_bht_data_i;
    logic [REG_W-1:0] cpu_reg_data_i;
    logic             btb_we_o, bht_we_o, reg_we_o;
    logic [7:0]       btb_addr_o, bht_addr_o;
    logic [4:0]       reg_addr_o;
    logic [BTB_W-1:0] btb_data_o;
    logic [BHT_W-1:0] bht_data_o;
    logic [REG_W-1:0] reg_data_o;
    logic             cpu_stall_o, init_done_o, seq_err_o;

    always #5 clk = ~clk;

    init_write_sequencer dut (
        .clk(clk), .rst_ni(rst_ni), .init_req_i(init_req_i),
        .gen_btb_data_i(gen_btb_data_i), .gen_btb_addr_i(gen_btb_addr_i),
        .gen_bht_data_i(gen_bht_data_i), .gen_bht_addr_i(gen_bht_addr_i),
        .gen_reg_data_i(gen_reg_data_i), .gen_reg_addr_i(gen_reg_addr_i),
        .cpu_btb_we_i(cpu_btb_we_i), .cpu_btb_addr_i(cpu_btb_addr_i), .cpu_btb_data_i(cpu_btb_data_i),
        .cpu_bht_we_i(cpu_bht_we_i), .cpu_bht_addr_i(cpu_bht_addr_i), .cpu_bht_data_i(cpu_bht_data_i),
        .cpu_reg_we_i(cpu_reg_we_i), .cpu_reg_addr_i(cpu_reg_addr_i), .cpu_reg_data_i(cpu_reg_data_i),
        .btb_we_o(btb_we_o), .btb_addr_o(btb_addr_o), .btb_data_o(btb_data_o),
        .bht_we_o(bht_we_o), .bht_addr_o(bht_addr_o), .bht_data_o(bht_data_o),
        .reg_we_o(reg_we_o), .reg_addr_o(reg_addr_o), .reg_data_o(reg_data_o),
        .cpu_stall_o(cpu_stall_o), .init_done_o(init_done_o), .seq_err_o(seq_err_o)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int DEPTH [3] = '{256, 256, 32};
    string tname [3] = '{"btb", "bht", "reg"};

    int          m_next [3];     // next index the sweep wants, -1 = waiting for 0
    bit          m_done [3];
    bit          m_sweep;
    logic        exp_we [3];
    logic [63:0] exp_addr [3];
    logic [63:0] exp_data [3];
    bit          exp_cmp [3];    // address/data meaningful this cycle
    logic        exp_stall, exp_idone, exp_err;

    // Monitor statistics, cleared by the stimulus between scenarios.
    int   edge_idx = -1;
    int   wr_cnt [3];
    int   first_edge [3], first_addr [3], last_edge [3], last_addr [3];
    int   err_cnt, err_edge, done_rise, btb_cpu_hits;
    logic prev_done = 1'b0;

    task automatic clear_stats();
        for (int t = 0; t < 3; t++) begin
            wr_cnt[t] = 0; first_edge[t] = -1; first_addr[t] = -1;
            last_edge[t] = -1; last_addr[t] = -1;
        end
        err_cnt = 0; err_edge = -1; done_rise = -1; btb_cpu_hits = 0;
    endtask

    always @(posedge clk) begin
        int          ga [3];
        logic [63:0] gd [3];
        logic        cw [3];
        logic [63:0] ca [3], cd [3];
        logic        aw [3];
        logic [63:0] aa [3], ad [3];
        bit          live;
        bit          all_done;

        ga[0] = int'(gen_btb_addr_i); gd[0] = 64'(gen_btb_data_i);
        ga[1] = int'(gen_bht_addr_i); gd[1] = 64'(gen_bht_data_i);
        ga[2] = int'(gen_reg_addr_i); gd[2] = 64'(gen_reg_data_i);
        cw[0] = cpu_btb_we_i; ca[0] = 64'(cpu_btb_addr_i); cd[0] = 64'(cpu_btb_data_i);
        cw[1] = cpu_bht_we_i; ca[1] = 64'(cpu_bht_addr_i); cd[1] = 64'(cpu_bht_data_i);
        cw[2] = cpu_reg_we_i; ca[2] = 64'(cpu_reg_addr_i); cd[2] = 64'(cpu_reg_data_i);
        live = (rst_ni === 1'b1);

        if (!live) begin
            m_sweep = 1'b1;
            for (int t = 0; t < 3; t++) begin
                m_next[t] = -1; m_done[t] = 1'b0;
                exp_we[t] = 1'b0; exp_addr[t] = '0; exp_data[t] = '0; exp_cmp[t] = 1'b1;
            end
            exp_err = 1'b0;
            edge_idx = -1;
        end else begin
            edge_idx++;
            exp_err = 1'b0;
            if (m_sweep) begin
                all_done = m_done[0] && m_done[1] && m_done[2];
                for (int t = 0; t < 3; t++) begin
                    exp_we[t] = 1'b0; exp_cmp[t] = 1'b0;
                end
                if (init_req_i) begin
                    for (int t = 0; t < 3; t++) begin
                        m_next[t] = -1; m_done[t] = 1'b0;
                    end
                end else if (all_done) begin
                    m_sweep = 1'b0;
                end else begin
                    for (int t = 0; t < 3; t++) begin
                        if (!m_done[t]) begin
                            if (m_next[t] >= 0 && ga[t] == m_next[t]) begin
                                exp_we[t] = 1'b1; exp_cmp[t] = 1'b1;
                                exp_addr[t] = 64'(ga[t]); exp_data[t] = gd[t];
                                m_next[t]++;
                                if (m_next[t] == DEPTH[t]) m_done[t] = 1'b1;
                            end else begin
                                if (m_next[t] >= 0) exp_err = 1'b1;
                                if (ga[t] == 0) begin
                                    exp_we[t] = 1'b1; exp_cmp[t] = 1'b1;
                                    exp_addr[t] = 64'(ga[t]); exp_data[t] = gd[t];
                                    m_next[t] = 1;
                                end else begin
                                    m_next[t] = -1;
                                end
                            end
                        end
                    end
                end
            end else begin
                for (int t = 0; t < 3; t++) begin
                    exp_we[t] = cw[t]; exp_addr[t] = ca[t]; exp_data[t] = cd[t]; exp_cmp[t] = 1'b1;
                end
                if (ca[2] == 0) exp_we[2] = 1'b0;
                if (init_req_i) begin
                    m_sweep = 1'b1;
                    for (int t = 0; t < 3; t++) begin
                        m_next[t] = -1; m_done[t] = 1'b0;
                    end
                end
            end
        end
        exp_stall = m_sweep;
        exp_idone = !m_sweep;

        #1;
        aw[0] = btb_we_o; aa[0] = 64'(btb_addr_o); ad[0] = 64'(btb_data_o);
        aw[1] = bht_we_o; aa[1] = 64'(bht_addr_o); ad[1] = 64'(bht_data_o);
        aw[2] = reg_we_o; aa[2] = 64'(reg_addr_o); ad[2] = 64'(reg_data_o);
        check("cpu_stall", 64'(cpu_stall_o), 64'(exp_stall));
        check("init_done", 64'(init_done_o), 64'(exp_idone));
        check("seq_err", 64'(seq_err_o), 64'(exp_err));
        for (int t = 0; t < 3; t++) begin
            check({tname[t], "_we"}, 64'(aw[t]), 64'(exp_we[t]));
            if (exp_cmp[t]) begin
                check({tname[t], "_addr"}, aa[t], exp_addr[t]);
                check({tname[t], "_data"}, ad[t], exp_data[t]);
            end
        end

        if (live) begin
            for (int t = 0; t < 3; t++) begin
                if (aw[t] === 1'b1) begin
                    wr_cnt[t]++;
                    if (first_edge[t] < 0) begin
                        first_edge[t] = edge_idx; first_addr[t] = int'(aa[t]);
                    end
                    last_edge[t] = edge_idx; last_addr[t] = int'(aa[t]);
                end
            end
            if (btb_we_o === 1'b1 && btb_data_o === 40'h12_3456_789A) btb_cpu_hits++;
            if (seq_err_o === 1'b1) begin
                err_cnt++; err_edge = edge_idx;
            end
            if (init_done_o === 1'b1 && prev_done !== 1'b1) done_rise = edge_idx;
        end
        prev_done = init_done_o;
    end

    // ---------------- stimulus ----------------
    // Generator beat for cycle i. skip=1 makes the register stream 0,1,2,3,5,6,...
    task automatic drive(input int i, input int btb_off, input int bht_off, input bit skip);
        gen_btb_addr_i = 8'((i + btb_off) % 256);
        gen_bht_addr_i = 8'((i + bht_off) % 256);
        gen_reg_addr_i = 5'(skip ? ((i < 4) ? i : (i + 1) % 32) : i % 32);
        gen_btb_data_i = {8'(i), 32'(32'hC0DE_0000 + i)};
        gen_bht_data_i = 2'(i ^ (i >> 2));
        gen_reg_data_i = 32'(32'h1000_0000 + i * 7);
    endtask

    // Drives cycles first..first+n-1. Called at a negedge, returns at a negedge.
    task automatic sweep(input int first, input int n, input int btb_off,
                         input int bht_off, input bit skip, input bit release_rst);
        for (int i = first; i < first + n; i++) begin
            drive(i, btb_off, bht_off, skip);
            if (release_rst && i == first) rst_ni = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        init_req_i = 1'b0;
        cpu_btb_we_i = 1'b0; cpu_bht_we_i = 1'b0; cpu_reg_we_i = 1'b0;
        repeat (2) @(negedge clk);
        clear_stats();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst_ni = 1'b0; init_req_i = 1'b0;
        cpu_btb_we_i = 1'b0; cpu_btb_addr_i = '0; cpu_btb_data_i = '0;
        cpu_bht_we_i = 1'b0; cpu_bht_addr_i = '0; cpu_bht_data_i = '0;
        cpu_reg_we_i = 1'b0; cpu_reg_addr_i = '0; cpu_reg_data_i = '0;
        drive(0, 0, 0, 1'b0);
        clear_stats();
        @(negedge clk);

        // 1) Aligned start. A pipeline BTB write held during the sweep must be dropped.
        do_reset();
        cpu_btb_we_i = 1'b1; cpu_btb_addr_i = 8'h55; cpu_btb_data_i = 40'h12_3456_789A;
        sweep(0, 250, 0, 0, 1'b0, 1'b1);
        cpu_btb_we_i = 1'b0;
        sweep(250, 50, 0, 0, 1'b0, 1'b0);
        check("s1_reg_count", 64'(wr_cnt[2]), 64'd32);
        check("s1_reg_first_addr", 64'(first_addr[2]), 64'd0);
        check("s1_reg_last", 64'(last_addr[2]), 64'd31);
        check("s1_reg_last_edge", 64'(last_edge[2]), 64'd31);
        check("s1_btb_count", 64'(wr_cnt[0]), 64'd256);
        check("s1_btb_last_edge", 64'(last_edge[0]), 64'd255);
        check("s1_btb_last_addr", 64'(last_addr[0]), 64'd255);
        check("s1_bht_count", 64'(wr_cnt[1]), 64'd256);
        check("s1_done_edge", 64'(done_rise), 64'd256);
        check("s1_err_count", 64'(err_cnt), 64'd0);
        check("s1_cpu_btb_dropped", 64'(btb_cpu_hits), 64'd0);

        // 2) BHT generator starts at 100.
        do_reset();
        sweep(0, 430, 0, 100, 1'b0, 1'b1);
        check("s2_bht_first_edge", 64'(first_edge[1]), 64'd156);
        check("s2_bht_first_addr", 64'(first_addr[1]), 64'd0);
        check("s2_bht_count", 64'(wr_cnt[1]), 64'd256);
        check("s2_bht_last_addr", 64'(last_addr[1]), 64'd255);
        check("s2_done_edge", 64'(done_rise), 64'd412);
        check("s2_err_count", 64'(err_cnt), 64'd0);

        // 3) Register stream skips address 4.
        do_reset();
        sweep(0, 270, 0, 0, 1'b1, 1'b1);
        check("s3_err_count", 64'(err_cnt), 64'd1);
        check("s3_err_edge", 64'(err_edge), 64'd4);
        check("s3_reg_count", 64'(wr_cnt[2]), 64'd36);
        check("s3_reg_last_edge", 64'(last_edge[2]), 64'd62);
        check("s3_reg_last_addr", 64'(last_addr[2]), 64'd31);
        check("s3_done_edge", 64'(done_rise), 64'd256);

        // 4) Passthrough in DONE.
        cpu_reg_we_i = 1'b1; cpu_reg_addr_i = 5'd7; cpu_reg_data_i = 32'hDEAD_BEEF;
        cpu_btb_we_i = 1'b1; cpu_btb_addr_i = 8'h3C; cpu_btb_data_i = 40'hAB_CDEF_0123;
        @(posedge clk); #2;
        check("s4_reg_we", 64'(reg_we_o), 64'd1);
        check("s4_reg_addr", 64'(reg_addr_o), 64'd7);
        check("s4_reg_data", 64'(reg_data_o), 64'hDEAD_BEEF);
        check("s4_btb_we", 64'(btb_we_o), 64'd1);
        check("s4_btb_addr", 64'(btb_addr_o), 64'h3C);
        check("s4_btb_data", 64'(btb_data_o), 64'hAB_CDEF_0123);
        @(negedge clk);
        cpu_btb_we_i = 1'b0;
        cpu_reg_addr_i = 5'd0; cpu_reg_data_i = 32'h1111_1111;
        @(posedge clk); #2;
        check("s4_x0_we", 64'(reg_we_o), 64'd0);
        @(negedge clk);

        // 5) Re-init from DONE. A pipeline write in the same cycle still lands.
        init_req_i = 1'b1;
        cpu_reg_we_i = 1'b1; cpu_reg_addr_i = 5'd9; cpu_reg_data_i = 32'h1234_5678;
        @(posedge clk); #2;
        check("s5_stall", 64'(cpu_stall_o), 64'd1);
        check("s5_init_done", 64'(init_done_o), 64'd0);
        check("s5_reg_we", 64'(reg_we_o), 64'd1);
        check("s5_reg_addr", 64'(reg_addr_o), 64'd9);
        check("s5_reg_data", 64'(reg_data_o), 64'h1234_5678);
        @(negedge clk);
        init_req_i = 1'b0; cpu_reg_we_i = 1'b0;
        base = edge_idx;
        clear_stats();
        sweep(0, 270, 0, 0, 1'b0, 1'b0);
        check("s5_btb_first_rel", 64'(first_edge[0] - base), 64'd1);
        check("s5_btb_count", 64'(wr_cnt[0]), 64'd256);
        check("s5_reg_count", 64'(wr_cnt[2]), 64'd32);
        check("s5_done_rel", 64'(done_rise - base), 64'd257);

        // 6) Reset at sweep cycle 100, then a fresh sweep.
        do_reset();
        sweep(0, 100, 0, 0, 1'b0, 1'b1);
        rst_ni = 1'b0;
        @(posedge clk); #2;
        check("s6_btb_we", 64'(btb_we_o), 64'd0);
        check("s6_btb_addr", 64'(btb_addr_o), 64'd0);
        check("s6_btb_data", 64'(btb_data_o), 64'd0);
        check("s6_bht_we", 64'(bht_we_o), 64'd0);
        check("s6_reg_we", 64'(reg_we_o), 64'd0);
        check("s6_reg_data", 64'(reg_data_o), 64'd0);
        check("s6_stall", 64'(cpu_stall_o), 64'd1);
        check("s6_init_done", 64'(init_done_o), 64'd0);
        @(negedge clk);
        do_reset();
        sweep(0, 270, 0, 0, 1'b0, 1'b1);
        check("s6_btb_count", 64'(wr_cnt[0]), 64'd256);
        check("s6_btb_first_edge", 64'(first_edge[0]), 64'd0);
        check("s6_done_edge", 64'(done_rise), 64'd256);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
